serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor; the inverse operation to the team's combinational N-bit adder.
//   - Accepts two WIDTH-bit operands over a valid/ready handshake.
//   - Computes a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
//   - Returns a (WIDTH+1)-bit two's-complement difference over a second valid/ready handshake.
//   - Sits in the arithmetic datapath where area matters more than throughput.
// PARAMETERS
//   WIDTH  4  operand width in bits; legal range 2..32
// PORTS
//   clk        in   1         single clock; all state updates on rising edge
//   rst_n      in   1         reset, synchronous, active-low
//   in_valid   in   1         operands a,b valid
//   in_ready   out  1         block can accept operands
//   a          in   WIDTH     minuend, unsigned
//   b          in   WIDTH     subtrahend, unsigned
//   out_valid  out  1         diff valid
//   out_ready  in   1         consumer accepts diff
//   diff       out  WIDTH+1   {borrow_out, a-b mod 2^WIDTH}; equals signed a-b
// BEHAVIOUR
//   - Reset: sampled only on rising clk while rst_n=0.
//     - state=IDLE, in_ready=0 during reset, out_valid=0, diff=0.
//     - Internal shift regs, borrow flop and bit counter are all cleared.
//   - FSM states IDLE -> SHIFT -> DONE -> IDLE.
//     - IDLE: in_ready=1. On in_valid&&in_ready:
//       - load a_sr=a and b_sr=b;
//       - clear borrow, cnt and res_sr;
//       - go to SHIFT.
//     - SHIFT: in_ready=0. Each cycle:
//       - d = a_sr[0]^b_sr[0]^borrow;
//       - borrow' = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow);
//       - shift a_sr and b_sr right, shift d into res_sr MSB, cnt++.
//       - After the WIDTH-th shift (cnt==WIDTH-1), register diff={borrow',res'} and go to DONE.
//     - DONE: out_valid=1 and diff held stable.
//       - On out_ready: out_valid drops next cycle and state goes to IDLE.
//       - While out_ready=0: hold indefinitely (backpressure).
//   - Latency: operands accepted at edge E0; out_valid=1 after edge E0+WIDTH.
//     - Max throughput is one result per WIDTH+2 cycles; no overlap of input and output phases.
//   - Width rule:
//     - diff[WIDTH-1:0] = (a-b) mod 2^WIDTH.
//     - diff[WIDTH] = 1 iff a<b.
//     - diff[WIDTH:0] is therefore the exact signed result in the range -(2^WIDTH-1) .. 2^WIDTH-1.
//   - Boundary conditions:
//     - a==b gives diff=0.
//     - Handshake signals in SHIFT/DONE are ignored (in_valid has no effect outside IDLE).
//     - diff does not change while out_valid=1.
//     - rst_n=0 mid-SHIFT or mid-DONE aborts the operation: next cycle is IDLE, out_valid=0, and no result is emitted.
//   - a and b need only be stable in the acceptance cycle.
// STRUCTURE
//   - Package serial_sub_pkg:
//     - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
//     - localparam DEFAULT_WIDTH = 4.
//   - Sub-module full_subtractor: inputs (x, y, bin), outputs (d, bout), purely combinational, one instance.
//   - Counter width is $clog2(WIDTH).
//   - All sequential logic in one always_ff with synchronous rst_n; next-state logic in always_comb.
// TESTING
//   1. Reset, WIDTH=4.
//      - Hold rst_n=0 for 2 cycles -> in_ready=0, out_valid=0, diff=5'b00000.
//      - After release, in_ready=1.
//   2. Send a=9, b=5 with out_ready=1.
//      - in_ready drops after acceptance.
//      - out_valid=1 exactly 4 cycles after the accept edge, diff=5'b00100.
//   3. Sweep underflow and extremes:
//      - a=3,  b=5  -> diff=5'b11110 (-2)
//      - a=0,  b=15 -> 5'b10001
//      - a=15, b=0  -> 5'b01111
//      - a=7,  b=7  -> 5'b00000
//   4. Backpressure: a=12, b=4 with out_ready=0 for 6 cycles.
//      - out_valid stays 1 and diff stays 5'b01000.
//      - Any in_valid pulses during the hold are ignored.
//      - Raise out_ready -> IDLE next cycle.
//   5. Reset mid-operation: accept a=10, b=3, then assert rst_n=0 on the 2nd SHIFT cycle.
//      - No out_valid ever appears.
//      - After release, a=2, b=1 -> diff=5'b00001.
//   6. Exhaustive back-to-back: all 256 a,b pairs with in_valid=1 and out_ready=1.
//      - diff == 5-bit (a-b) for every pair.
//      - Each result issues WIDTH+2 cycles after the previous one.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout set on underflow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic xy_eq;

  assign xy_eq = ~(x ^ y);
  assign d     = x ^ y ^ bin;
  // Borrow when y exceeds x outright, or when they tie and a borrow ripples in.
  assign bout  = (~x & y) | (xy_eq & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first through one full_subtractor cell.
// Result is a (WIDTH+1)-bit two's-complement difference behind a valid/ready pair.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sub_state_t       state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   diff_q;
  logic             fs_d, fs_bout;
  logic             accept, last;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept)    nxt = SHIFT;
      SHIFT:   if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          borrow <= fs_bout;
          cnt    <= cnt + CW'(1);
          // Final borrow is the sign bit of the widened difference.
          if (last) diff_q <= {fs_bout, fs_d, res_sr[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // Held low while reset is asserted so nothing is taken mid-reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   diff;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one acceptance cycle; afterwards operands are scrambled.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep_valid);
    a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = keep_valid;
    a = ~av; b = av ^ bv;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step(); step();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vecs++; if (diff !== 5'b00000) begin errs++; $display("FAIL rst_diff got %b want 00000", diff); end
    rst_n = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'd9, 4'd5, 1'b0);
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL basic_in_ready got %b want 0", in_ready); end
    step(); step(); step();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early got out_valid=%b want 0 at E0+3", out_valid); end
    step();
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_latency got out_valid=%b want 1 at E0+4", out_valid); end
    vecs++; if (diff !== 5'b00100) begin errs++; $display("FAIL basic_diff got %b want 00100", diff); end
    step();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL basic_idle got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_underflow();
    logic [W-1:0] ta [4] = '{4'd3, 4'd0, 4'd15, 4'd7};
    logic [W-1:0] tb [4] = '{4'd5, 4'd15, 4'd0, 4'd7};
    logic [W:0]   te [4] = '{5'b11110, 5'b10001, 5'b01111, 5'b00000};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], 1'b0);
      wait_valid(n);
      vecs++; if (n !== 4) begin errs++; $display("FAIL sweep%0d_latency got %0d want 4", i, n); end
      vecs++; if (diff !== te[i]) begin errs++; $display("FAIL sweep%0d_diff got %b want %b", i, diff, te[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    send(4'd12, 4'd4, 1'b0);
    wait_valid(n);
    vecs++; if (n !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", n); end
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; a = 4'(i); b = 4'(15 - i);
      step();
      vecs++; if (out_valid !== 1'b1 || diff !== 5'b01000) begin
        errs++; $display("FAIL bp_hold%0d got out_valid=%b diff=%b want 1/01000", i, out_valid, diff); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen = 1'b0;
    out_ready = 1'b1;
    send(4'd10, 4'd3, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL mid_rst got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_abort got out_valid seen=%b want 0", seen); end
    send(4'd2, 4'd1, 1'b0);
    wait_valid(n);
    vecs++; if (diff !== 5'b00001 || out_valid !== 1'b1) begin
      errs++; $display("FAIL mid_after got diff=%b out_valid=%b want 00001/1", diff, out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    int n, prev, now;
    logic [W:0] exp;
    prev = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] av, bv;
      av = 4'(i >> 4); bv = 4'(i);
      send(av, bv, 1'b1);
      wait_valid(n);
      now = cyc;
      exp = {1'b0, av} - {1'b0, bv};
      vecs++; if (out_valid !== 1'b1 || diff !== exp) begin
        errs++; $display("FAIL b2b a=%0d b=%0d got diff=%b valid=%b want %b", av, bv, diff, out_valid, exp); end
      if (prev >= 0) begin
        vecs++; if (now - prev !== W + 2) begin
          errs++; $display("FAIL b2b_period a=%0d b=%0d got %0d want %0d", av, bv, now - prev, W + 2); end
      end
      prev = now;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
